// File: rtl/nn_access_arbiter.sv
// nn_access_arbiter
// Shares one MLP classifier between the training controller and the
// inference path. Each granted transaction holds the MLP inputs stable for
// LAT cycles, strobes learn once (training with learn enabled only), then
// emits a one-cycle done pulse. Inference wins ties unless training has
// been passed over MAX_STARVE times in a row.
module nn_access_arbiter #(
    parameter int LAT        = 4,
    parameter int MAX_STARVE = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tr_req,
    input  logic [15:0] tr_x,
    input  logic        tr_is_O,
    input  logic        tr_learn,
    output logic        tr_gnt,
    output logic        tr_done,
    input  logic        inf_req,
    input  logic [15:0] inf_x,
    output logic        inf_gnt,
    output logic        inf_done,
    output logic        inf_y,
    output logic [6:0]  inf_prob,
    output logic [15:0] nn_x,
    output logic        nn_learn,
    output logic        nn_is_O,
    input  logic        nn_y,
    input  logic [6:0]  nn_prob,
    output logic        busy,
    output logic        owner
);

    localparam int                CNT_W      = $clog2(LAT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(LAT - 1);
    localparam logic [7:0]        STARVE_MAX = 8'(MAX_STARVE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [7:0]       starve_cnt_r;
    logic             grant_tr_s;
    logic             grant_inf_s;
    logic             starved_s;

    // Arbitration on sampled requests; only meaningful while idle.
    always_comb begin
        grant_tr_s  = 1'b0;
        grant_inf_s = 1'b0;
        starved_s   = (starve_cnt_r == STARVE_MAX);
        if (state_r == ST_IDLE) begin
            if (tr_req && inf_req) begin
                if (starved_s) begin
                    grant_tr_s = 1'b1;
                end else begin
                    grant_inf_s = 1'b1;
                end
            end else if (tr_req) begin
                grant_tr_s = 1'b1;
            end else if (inf_req) begin
                grant_inf_s = 1'b1;
            end else begin
                grant_tr_s  = 1'b0;
                grant_inf_s = 1'b0;
            end
        end else begin
            grant_tr_s  = 1'b0;
            grant_inf_s = 1'b0;
        end
    end

    // Count inference wins while training waits; saturates at MAX_STARVE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_r <= 8'd0;
        end else if (!tr_req || grant_tr_s) begin
            starve_cnt_r <= 8'd0;
        end else if (grant_inf_s && (starve_cnt_r != STARVE_MAX)) begin
            starve_cnt_r <= starve_cnt_r + 8'd1;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            tr_gnt   <= 1'b0;
            tr_done  <= 1'b0;
            inf_gnt  <= 1'b0;
            inf_done <= 1'b0;
            inf_y    <= 1'b0;
            inf_prob <= 7'd0;
            nn_x     <= 16'd0;
            nn_learn <= 1'b0;
            nn_is_O  <= 1'b0;
            busy     <= 1'b0;
            owner    <= 1'b0;
        end else begin
            // Pulses default low; only set for a single cycle below.
            tr_gnt   <= 1'b0;
            inf_gnt  <= 1'b0;
            tr_done  <= 1'b0;
            inf_done <= 1'b0;
            nn_learn <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_tr_s || grant_inf_s) begin
                        state_r  <= ST_RUN;
                        cnt_r    <= {CNT_W{1'b0}};
                        busy     <= 1'b1;
                        owner    <= grant_inf_s;
                        tr_gnt   <= grant_tr_s;
                        inf_gnt  <= grant_inf_s;
                        nn_x     <= grant_inf_s ? inf_x : tr_x;
                        nn_is_O  <= grant_tr_s & tr_is_O;
                        // Learn strobe lands in the first RUN cycle only.
                        nn_learn <= grant_tr_s & tr_learn;
                    end else begin
                        busy    <= 1'b0;
                        owner   <= 1'b0;
                        nn_x    <= 16'd0;
                        nn_is_O <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_DONE;
                        if (owner) begin
                            inf_done <= 1'b1;
                            inf_y    <= nn_y;
                            inf_prob <= nn_prob;
                        end else begin
                            tr_done <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    owner   <= 1'b0;
                    nn_x    <= 16'd0;
                    nn_is_O <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    owner   <= 1'b0;
                    nn_x    <= 16'd0;
                    nn_is_O <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nn_access_arbiter.sv
// Self-checking bench for nn_access_arbiter: expected transactions are
// queued when requests are driven and checked when grants/dones appear.
module tb_nn_access_arbiter;

    logic        clk;
    logic        rst;
    logic        tr_req;
    logic [15:0] tr_x;
    logic        tr_is_O;
    logic        tr_learn;
    logic        tr_gnt;
    logic        tr_done;
    logic        inf_req;
    logic [15:0] inf_x;
    logic        inf_gnt;
    logic        inf_done;
    logic        inf_y;
    logic [6:0]  inf_prob;
    logic [15:0] nn_x;
    logic        nn_learn;
    logic        nn_is_O;
    logic        nn_y;
    logic [6:0]  nn_prob;
    logic        busy;
    logic        owner;

    logic        mlp_y;
    logic [6:0]  mlp_prob;
    assign nn_y    = mlp_y;
    assign nn_prob = mlp_prob;

    typedef struct {
        logic        owner;
        logic [15:0] x;
        logic        is_o;
        logic        learn;
        logic        y;
        logic [6:0]  prob;
    } txn_t;

    txn_t        exp_q[$];
    txn_t        run_q[$];
    txn_t        e;
    logic        model_y;
    logic [6:0]  model_prob;
    int          n_tests;
    int          n_fail;
    int          learn_cnt;
    int          learn0;

    nn_access_arbiter #(.LAT(4), .MAX_STARVE(2)) dut (
        .clk(clk), .rst(rst),
        .tr_req(tr_req), .tr_x(tr_x), .tr_is_O(tr_is_O), .tr_learn(tr_learn),
        .tr_gnt(tr_gnt), .tr_done(tr_done),
        .inf_req(inf_req), .inf_x(inf_x), .inf_gnt(inf_gnt), .inf_done(inf_done),
        .inf_y(inf_y), .inf_prob(inf_prob),
        .nn_x(nn_x), .nn_learn(nn_learn), .nn_is_O(nn_is_O),
        .nn_y(nn_y), .nn_prob(nn_prob),
        .busy(busy), .owner(owner)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the middle of the next cycle (4 time units after posedge).
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #4;
        end
    endtask

    // Scoreboard monitor: grants pop the expected queue, dones pop in-flight.
    always @(negedge clk) begin
        if (rst) begin
            if (tr_gnt || inf_gnt) begin
                if (exp_q.size() == 0) begin
                    check_eq("gnt_unexpected", 32'(1), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    check_eq("gnt_who",   32'({tr_gnt, inf_gnt}), 32'({~e.owner, e.owner}));
                    check_eq("gnt_nn_x",  32'(nn_x),    32'(e.x));
                    check_eq("gnt_is_O",  32'(nn_is_O), 32'(e.is_o));
                    check_eq("gnt_learn", 32'(nn_learn), 32'(e.learn));
                    check_eq("gnt_owner", 32'(owner),   32'(e.owner));
                    check_eq("gnt_busy",  32'(busy),    32'(1));
                    run_q.push_back(e);
                end
            end else begin
                check_eq("learn_quiet", 32'(nn_learn), 32'(0));
            end
            if (nn_learn) learn_cnt++;
            if (tr_done || inf_done) begin
                if (run_q.size() == 0) begin
                    check_eq("done_unexpected", 32'(1), 32'(0));
                end else begin
                    e = run_q.pop_front();
                    check_eq("done_who", 32'({tr_done, inf_done}), 32'({~e.owner, e.owner}));
                    if (e.owner) begin
                        model_y    = e.y;
                        model_prob = e.prob;
                    end
                    check_eq("done_inf_y",    32'(inf_y),    32'(model_y));
                    check_eq("done_inf_prob", 32'(inf_prob), 32'(model_prob));
                end
            end
        end
    end

    initial begin
        n_tests = 0; n_fail = 0; learn_cnt = 0; learn0 = 0;
        rst = 1'b0; tr_req = 1'b0; tr_x = 16'd0; tr_is_O = 1'b0; tr_learn = 1'b0;
        inf_req = 1'b0; inf_x = 16'd0; mlp_y = 1'b0; mlp_prob = 7'd0;
        model_y = 1'b0; model_prob = 7'd0;

        // Reset state
        step(2);
        check_eq("rst_outputs", 32'({tr_gnt, tr_done, inf_gnt, inf_done, inf_y, inf_prob,
                                     nn_x, nn_learn, nn_is_O, busy, owner}), 32'd0);
        rst = 1'b1;
        step(1);

        // Single inference
        mlp_y = 1'b1; mlp_prob = 7'd87; inf_x = 16'h0F0F; inf_req = 1'b1;
        exp_q.push_back('{1'b1, 16'h0F0F, 1'b0, 1'b0, 1'b1, 7'd87});
        learn0 = learn_cnt;
        for (int c = 1; c <= 6; c++) begin
            step(1);
            if (c == 1) inf_req = 1'b0;
            check_eq("t1_gnt",  32'(inf_gnt),  32'(c == 1));
            check_eq("t1_busy", 32'(busy),     32'(c <= 5));
            check_eq("t1_nn_x", 32'(nn_x),     (c <= 5) ? 32'h0F0F : 32'h0);
            check_eq("t1_done", 32'(inf_done), 32'(c == 5));
            if (c == 5) begin
                check_eq("t1_inf_y",    32'(inf_y),    32'(1));
                check_eq("t1_inf_prob", 32'(inf_prob), 32'd87);
            end
        end
        check_eq("t1_no_learn", 32'(learn_cnt - learn0), 32'd0);

        // Single training with learn
        mlp_y = 1'b0; mlp_prob = 7'd12; tr_x = 16'h1234; tr_is_O = 1'b1; tr_learn = 1'b1;
        tr_req = 1'b1;
        exp_q.push_back('{1'b0, 16'h1234, 1'b1, 1'b1, 1'b0, 7'd0});
        learn0 = learn_cnt;
        for (int c = 1; c <= 6; c++) begin
            step(1);
            if (c == 1) tr_req = 1'b0;
            check_eq("t2_gnt",   32'(tr_gnt),   32'(c == 1));
            check_eq("t2_learn", 32'(nn_learn), 32'(c == 1));
            check_eq("t2_is_O",  32'(nn_is_O),  32'(c <= 5));
            check_eq("t2_done",  32'(tr_done),  32'(c == 5));
            if (c == 5) begin
                check_eq("t2_inf_y_hold",    32'(inf_y),    32'(1));
                check_eq("t2_inf_prob_hold", 32'(inf_prob), 32'd87);
            end
        end
        check_eq("t2_learn_count", 32'(learn_cnt - learn0), 32'd1);

        // Both requests held: starvation bound of 2
        mlp_y = 1'b0; mlp_prob = 7'd33; tr_x = 16'hAAAA; tr_is_O = 1'b0; tr_learn = 1'b1;
        inf_x = 16'h5555; tr_req = 1'b1; inf_req = 1'b1;
        for (int g = 0; g < 6; g++) begin
            if ((g % 3) == 2) exp_q.push_back('{1'b0, 16'hAAAA, 1'b0, 1'b1, 1'b0, 7'd0});
            else              exp_q.push_back('{1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, 7'd33});
        end
        for (int c = 1; c <= 37; c++) begin
            step(1);
            if (c == 31) begin
                tr_req = 1'b0; inf_req = 1'b0;
            end
            check_eq("t3_spacing", 32'(tr_gnt | inf_gnt), 32'(((c % 6) == 1) && (c <= 31)));
        end
        check_eq("t3_exp_drained", 32'(exp_q.size()), 32'd0);
        check_eq("t3_run_drained", 32'(run_q.size()), 32'd0);

        // Back-to-back training samples
        tr_x = 16'h0101; tr_is_O = 1'b1; tr_learn = 1'b1; tr_req = 1'b1;
        exp_q.push_back('{1'b0, 16'h0101, 1'b1, 1'b1, 1'b0, 7'd0});
        exp_q.push_back('{1'b0, 16'h0202, 1'b1, 1'b1, 1'b0, 7'd0});
        exp_q.push_back('{1'b0, 16'h0303, 1'b1, 1'b1, 1'b0, 7'd0});
        learn0 = learn_cnt;
        for (int c = 1; c <= 18; c++) begin
            step(1);
            if (c == 1)  tr_x = 16'h0202;
            if (c == 7)  tr_x = 16'h0303;
            if (c == 13) tr_req = 1'b0;
            check_eq("t4_gnt",  32'(tr_gnt), 32'((c == 1) || (c == 7) || (c == 13)));
            check_eq("t4_busy", 32'(busy),   32'((c <= 17) && (c != 6) && (c != 12)));
        end
        check_eq("t4_learn_count", 32'(learn_cnt - learn0), 32'd3);

        // Reset mid-RUN aborts the inference
        mlp_y = 1'b1; mlp_prob = 7'd55; inf_x = 16'hFFFF; inf_req = 1'b1;
        exp_q.push_back('{1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 7'd55});
        step(1);
        inf_req = 1'b0;
        step(2);
        rst = 1'b0;
        #1;
        check_eq("t5_abort_outputs", 32'({tr_gnt, tr_done, inf_gnt, inf_done, inf_y, inf_prob,
                                          nn_x, nn_learn, nn_is_O, busy, owner}), 32'd0);
        run_q.delete();
        model_y = 1'b0; model_prob = 7'd0;
        step(2);
        rst = 1'b1;
        step(2);
        mlp_y = 1'b0; mlp_prob = 7'd5; inf_x = 16'h0033; inf_req = 1'b1;
        exp_q.push_back('{1'b1, 16'h0033, 1'b0, 1'b0, 1'b0, 7'd5});
        step(1);
        check_eq("t5_regrant", 32'(inf_gnt), 32'(1));
        inf_req = 1'b0;
        step(5);
        check_eq("t5_idle",     32'(busy),     32'(0));
        check_eq("t5_inf_prob", 32'(inf_prob), 32'd5);

        // Request dropped after grant: transaction still completes
        mlp_y = 1'b1; mlp_prob = 7'd100; inf_x = 16'h00AA; inf_req = 1'b1;
        exp_q.push_back('{1'b1, 16'h00AA, 1'b0, 1'b0, 1'b1, 7'd100});
        for (int c = 1; c <= 8; c++) begin
            step(1);
            if (c == 2) inf_req = 1'b0;
            check_eq("t6_gnt",  32'(inf_gnt),  32'(c == 1));
            check_eq("t6_done", 32'(inf_done), 32'(c == 5));
        end
        check_eq("t6_inf_y", 32'(inf_y), 32'(1));

        check_eq("end_exp_drained", 32'(exp_q.size()), 32'd0);
        check_eq("end_run_drained", 32'(run_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nn_access_arbiter.md
# nn_access_arbiter

Sequences and shares the single `mlp_OX` classifier between two requesters: the training controller (sample-by-sample learn transactions) and the inference path (submit-triggered classification of the user pattern). It replaces the combinational training/inference mux in `top` with a handshaked, transaction-based scheduler. Each transaction holds the network inputs stable for a fixed settle latency, fires `learn` exactly once, then returns a completion pulse and latched result. Inference has priority, and a starvation bound protects training progress.

## Interface
- `LAT`, 4, cycles the MLP needs from stable `nn_x` to a valid `nn_y`/`nn_prob`; legal range 1–255.
- `MAX_STARVE`, 8, consecutive inference grants allowed while `tr_req` is pending before training is forced; legal range 1–255.

- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low
- `tr_req`  in  1  training transaction request; held until `tr_gnt`
- `tr_x`  in  16  training pattern
- `tr_is_O`  in  1  training label
- `tr_learn`  in  1  1 = weight update, 0 = evaluate only
- `tr_gnt`  out  1  one-cycle pulse; training operands captured
- `tr_done`  out  1  one-cycle pulse; training transaction complete
- `inf_req`  in  1  inference request; held until `inf_gnt`
- `inf_x`  in  16  user input flags
- `inf_gnt`  out  1  one-cycle pulse; inference operands captured
- `inf_done`  out  1  one-cycle pulse; `inf_y`/`inf_prob` updated
- `inf_y`  out  1  latched classification (1 = O)
- `inf_prob`  out  7  latched O probability, 0–100
- `nn_x`  out  16  MLP input
- `nn_learn`  out  1  MLP learn strobe
- `nn_is_O`  out  1  MLP label
- `nn_y`  in  1  MLP output
- `nn_prob`  in  7  MLP probability output
- `busy`  out  1  high in RUN and DONE
- `owner`  out  1  0 = training, 1 = inference; valid while `busy`

## Operation
- States:
  - IDLE → RUN when any request is granted.
  - RUN → DONE after `LAT` cycles.
  - DONE → IDLE unconditionally.
- Arbitration (IDLE only, on sampled requests):
  - Only one requester active: grant it.
  - Both active: grant inference, unless `starve_cnt == MAX_STARVE`, in which case grant training.
- Starvation counter `starve_cnt` (8-bit, saturating at `MAX_STARVE`):
  - Increments on each inference grant while `tr_req` is high.
  - Clears on any training grant, or in any cycle `tr_req` is low.
- On grant, register the operands:
  - `nn_x` ← requester's x.
  - `nn_is_O` ← `tr_is_O` (training) or 0 (inference).
  - `owner` is set.
- `nn_learn` is 1 only in the first RUN cycle, and only if the owner is training and `tr_learn` was 1 at grant. It is 0 at all other times, so each training sample updates weights exactly once.
- `nn_x` and `nn_is_O` hold their captured values through RUN and DONE; they are 0 in IDLE.
- Request deassertion after grant is ignored; the transaction always completes.
- On the RUN→DONE edge, for an inference owner only: `inf_y` ← `nn_y`, `inf_prob` ← `nn_prob`. These hold until the next inference completes.
- RUN counter width is ceil(log2(LAT+1)); the counter runs 0..LAT-1.

## Timing
- Reset (async assert): state IDLE; every output 0; `starve_cnt` 0. Reset mid-transaction aborts it with no `done` pulse.
- Request high in IDLE at cycle 0:
  - `gnt`, `busy`, and the first RUN cycle (with `learn`) all occur in cycle 1.
  - RUN occupies cycles 1..LAT.
  - DONE occurs in cycle LAT+1, with the `done` pulse and valid `inf_y`.
  - IDLE occurs in cycle LAT+2.
- Minimum transaction period is LAT+2 cycles; the next grant comes no earlier than cycle LAT+3.
- All outputs are registered; no combinational path from any `*_req` to any `*_gnt`.
- `tr_gnt`/`inf_gnt` and `tr_done`/`inf_done` are mutually exclusive, and each pulses exactly once per transaction.

## Test plan
- Reset then single inference: `inf_x`=16'h0F0F, LAT=4, `nn_y`=1, `nn_prob`=87.
  - Expect `inf_gnt` at cycle 1, `nn_x`=16'h0F0F for cycles 1–5.
  - Expect `inf_done` at cycle 5 with `inf_y`=1, `inf_prob`=87; `nn_learn` never 1.
- Single training with `tr_learn`=1, `tr_is_O`=1:
  - Expect `nn_learn` high only in cycle 1; `nn_is_O`=1 for cycles 1–5.
  - Expect `tr_done` at cycle 5; `inf_y`/`inf_prob` unchanged.
- Simultaneous requests, both held continuously, MAX_STARVE=2:
  - Expect grant order inference, inference, training, inference, inference, training.
  - Grants spaced 6 cycles apart.
- Back-to-back: `tr_req` held for 3 samples.
  - Expect `tr_gnt` at cycles 1, 7, 13 and exactly 3 `nn_learn` pulses.
  - Expect `busy` low in cycles 6 and 12.
- Mid-RUN abort: assert `rst` at cycle 3 of an inference.
  - Expect all outputs 0 immediately and no `inf_done`.
  - After release, a new request is granted one cycle after it is sampled.
- Request drop: `inf_req` deasserted at cycle 2 after grant.
  - Expect the transaction to complete, with `inf_done` at cycle 5.
